fixed_priority_arbitor: RTL and testbench
=========================================

# fixed_priority_arbitor

Parameterised fixed-priority arbiter: bit 0 has the highest priority, and the lowest-indexed asserted request wins. The combinational grant path is the block's primary output and can be used as a drop-in request selector inside bus and memory muxes. A clocked stage re-registers the decision and adds an optional grant lock, so multi-cycle transfers keep ownership. All outputs are derived from a single priority decision.

## Interface
- width, default 2 — number of requesters; legal range 1..32.
- IDX_W, derived localparam — max(1, ceil(log2(width))).
- clk  input  1  rising-edge clock for the registered stage.
- rst_x  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- i_request  input  width  request vector; bit n is requester n.
- i_lock  input  1  when high, the registered grant holds its current owner while that owner keeps requesting.
- o_grant  output  width  combinational one-hot (or zero) grant.
- o_grant_valid  output  1  combinational; high when i_request is nonzero.
- o_grant_index  output  IDX_W  combinational binary index of the o_grant bit; 0 when there is no request.
- o_grant_q  output  width  registered grant, after lock.
- o_grant_index_q  output  IDX_W  registered index.
- o_grant_valid_q  output  1  registered valid.

## Operation
- o_grant[n] = i_request[n] AND no lower-indexed request is set. Equivalently, o_grant = i_request & (~i_request + 1), truncated to width.
- o_grant is at most one-hot, and all zeros when i_request is zero.
- o_grant is purely combinational from i_request. It is independent of clk, rst_x and i_lock, and is valid even while rst_x is low.
- o_grant_index is the encode of o_grant. o_grant_valid = |i_request.
- Registered stage, next-state logic:
  - If i_lock = 1, o_grant_valid_q = 1 and (i_request & o_grant_q) != 0: keep o_grant_q and o_grant_index_q unchanged. The locked owner wins even if a higher-priority request appears.
  - Otherwise: load o_grant, o_grant_index and o_grant_valid.
- Dropping the owner's request releases the lock on the next edge, even if i_lock stays high. The new winner is chosen by fixed priority.
- No fairness is provided. A persistently asserted lower bit can starve higher bits; this is by design.
- width = 1: o_grant = i_request; indices are always 0.

## Timing
- Combinational path: zero cycles. The grant settles within the same time step that i_request changes.
- Registered path: exactly one clk cycle of latency from i_request/i_lock to the _q outputs.
- Reset: while rst_x = 0, o_grant_q = 0, o_grant_index_q = 0 and o_grant_valid_q = 0, applied immediately without waiting for a clock edge.
- Reset release: the first rising clk edge after rst_x goes high loads the unlocked decision.
- Reset asserted mid-lock: the registered outputs clear immediately and the lock is lost.
- Simultaneous requests: resolved by index only, with the lowest index winning.
- Request change on the same edge as a lock release: the new vector is arbitrated on that edge.

## Test plan
- Combinational sweep, width=4: i_request 0000/0001/0010/0100/1000/0101/1110/1111 -> o_grant 0000/0001/0010/0100/1000/0001/0010/0001, each checked 1 time step after the change. o_grant_index = 0/0/1/2/3/0/1/0. o_grant_valid is 0 only for 0000.
- Default width=2, i_request bits [1:0] of the same stimulus -> o_grant 00/01/10/00/00/01/10/01.
- Reset: hold rst_x=0 with i_request=1111 and clock running -> all _q outputs are 0, while o_grant = 0001. Release reset -> o_grant_q = 0001 after the 1st edge.
- Lock hold: i_request=0100 then i_lock=1, one edge later raise i_request to 0101 -> o_grant_q stays 0100 and o_grant is 0001. Drop bit 2 -> o_grant_q = 0001 on the next edge.
- No lock: i_lock=0, i_request 0100 -> 0101 -> o_grant_q changes to 0001 one cycle later.
- Exhaustive random, width=8, 1000 vectors: o_grant is one-hot or zero, is a subset of i_request, and no lower request bit is set below the granted bit.

Source files
------------

// File: rtl/fixed_priority_arbitor.sv
// Fixed-priority arbiter: the lowest-indexed asserted request wins.
// Combinational grant for muxing, plus a registered copy with an owner lock.
module fixed_priority_arbitor #(
  parameter  int width = 2,
  localparam int IDX_W = (width > 1) ? $clog2(width) : 1
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic [width-1:0] i_request,
  input  logic             i_lock,
  output logic [width-1:0] o_grant,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_index,
  output logic [width-1:0] o_grant_q,
  output logic [IDX_W-1:0] o_grant_index_q,
  output logic             o_grant_valid_q
);

  logic [width-1:0] w_grant;
  logic [IDX_W-1:0] w_index;
  logic             w_valid;
  logic             w_hold;

  logic [width-1:0] r_grant_q;
  logic [IDX_W-1:0] r_index_q;
  logic             r_valid_q;

  // Two's-complement trick isolates the lowest set request bit.
  assign w_grant = i_request & (~i_request + width'(1));
  assign w_valid = |i_request;

  always_comb begin
    w_index = '0;
    for (int n = 0; n < width; n++) begin
      if (w_grant[n]) w_index = IDX_W'(n);
    end
  end

  // The current owner keeps the grant only while it is still requesting.
  assign w_hold = i_lock & r_valid_q & (|(i_request & r_grant_q));

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_grant_q <= '0;
      r_index_q <= '0;
      r_valid_q <= 1'b0;
    end else if (!w_hold) begin
      r_grant_q <= w_grant;
      r_index_q <= w_index;
      r_valid_q <= w_valid;
    end
  end

  assign o_grant         = w_grant;
  assign o_grant_valid   = w_valid;
  assign o_grant_index   = w_index;
  assign o_grant_q       = r_grant_q;
  assign o_grant_index_q = r_index_q;
  assign o_grant_valid_q = r_valid_q;

endmodule

// File: tb/tb_fixed_priority_arbitor.sv
// Testbench for fixed_priority_arbitor: table-driven sweep, lock/reset sequences,
// and randomized vectors against a lowest-set-bit reference model.
module tb_fixed_priority_arbitor;

  logic clk = 1'b0;
  logic rst_x;
  always #5 clk = ~clk;

  // width = 4 instance
  logic [3:0] req4;
  logic       lock4;
  logic [3:0] gnt4, gnt4_q;
  logic [1:0] idx4, idx4_q;
  logic       vld4, vld4_q;

  // default width = 2 instance
  logic [1:0] req2;
  logic [1:0] gnt2, gnt2_q;
  logic [0:0] idx2, idx2_q;
  logic       vld2, vld2_q;

  // width = 8 instance
  logic [7:0] req8;
  logic       lock8;
  logic [7:0] gnt8, gnt8_q;
  logic [2:0] idx8, idx8_q;
  logic       vld8, vld8_q;

  // width = 1 instance
  logic [0:0] req1;
  logic [0:0] gnt1, gnt1_q;
  logic [0:0] idx1, idx1_q;
  logic       vld1, vld1_q;

  fixed_priority_arbitor #(.width(4)) u_dut4 (
    .clk(clk), .rst_x(rst_x), .i_request(req4), .i_lock(lock4),
    .o_grant(gnt4), .o_grant_valid(vld4), .o_grant_index(idx4),
    .o_grant_q(gnt4_q), .o_grant_index_q(idx4_q), .o_grant_valid_q(vld4_q));

  fixed_priority_arbitor u_dut2 (
    .clk(clk), .rst_x(rst_x), .i_request(req2), .i_lock(1'b0),
    .o_grant(gnt2), .o_grant_valid(vld2), .o_grant_index(idx2),
    .o_grant_q(gnt2_q), .o_grant_index_q(idx2_q), .o_grant_valid_q(vld2_q));

  fixed_priority_arbitor #(.width(8)) u_dut8 (
    .clk(clk), .rst_x(rst_x), .i_request(req8), .i_lock(lock8),
    .o_grant(gnt8), .o_grant_valid(vld8), .o_grant_index(idx8),
    .o_grant_q(gnt8_q), .o_grant_index_q(idx8_q), .o_grant_valid_q(vld8_q));

  fixed_priority_arbitor #(.width(1)) u_dut1 (
    .clk(clk), .rst_x(rst_x), .i_request(req1), .i_lock(lock8),
    .o_grant(gnt1), .o_grant_valid(vld1), .o_grant_index(idx1),
    .o_grant_q(gnt1_q), .o_grant_index_q(idx1_q), .o_grant_valid_q(vld1_q));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: index of the lowest set bit, -1 when none.
  function automatic int lowest(input logic [31:0] v, input int w);
    for (int i = 0; i < w; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int idx);
    return (idx < 0) ? 32'd0 : (32'd1 << idx);
  endfunction

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    int         idx;
    logic       vld;
    logic [1:0] gnt2;
  } vec_t;

  vec_t tbl[8];

  int ref_own8;
  int ref_own1;

  initial begin
    tbl[0] = '{4'b0000, 4'b0000, 0, 1'b0, 2'b00};
    tbl[1] = '{4'b0001, 4'b0001, 0, 1'b1, 2'b01};
    tbl[2] = '{4'b0010, 4'b0010, 1, 1'b1, 2'b10};
    tbl[3] = '{4'b0100, 4'b0100, 2, 1'b1, 2'b00};
    tbl[4] = '{4'b1000, 4'b1000, 3, 1'b1, 2'b00};
    tbl[5] = '{4'b0101, 4'b0001, 0, 1'b1, 2'b01};
    tbl[6] = '{4'b1110, 4'b0010, 1, 1'b1, 2'b10};
    tbl[7] = '{4'b1111, 4'b0001, 0, 1'b1, 2'b01};

    rst_x = 1'b0;
    req4 = 4'b1111; lock4 = 1'b0;
    req2 = 2'b00; req8 = 8'd0; lock8 = 1'b0; req1 = 1'b0;
    ref_own8 = -1; ref_own1 = -1;

    // Reset held with clock running: registered outputs stay clear, comb path live.
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant_q", gnt4_q, 4'b0000);
    check("rst_index_q", idx4_q, 2'd0);
    check("rst_valid_q", vld4_q, 1'b0);
    check("rst_comb_grant", gnt4, 4'b0001);
    @(negedge clk) rst_x = 1'b1;
    @(posedge clk) #1;
    check("rst_rel_grant_q", gnt4_q, 4'b0001);
    check("rst_rel_valid_q", vld4_q, 1'b1);

    // Combinational sweep, width 4 and width 2.
    for (int i = 0; i < 8; i++) begin
      req4 = tbl[i].req;
      req2 = tbl[i].req[1:0];
      #1;
      check($sformatf("sweep%0d_grant", i), gnt4, tbl[i].gnt);
      check($sformatf("sweep%0d_index", i), idx4, tbl[i].idx);
      check($sformatf("sweep%0d_valid", i), vld4, tbl[i].vld);
      check($sformatf("sweep%0d_grant_w2", i), gnt2, tbl[i].gnt2);
    end

    // Lock hold against a higher-priority newcomer, then release by dropping owner.
    @(negedge clk) begin req4 = 4'b0100; lock4 = 1'b0; end
    @(posedge clk) #1;
    check("lock_setup_q", gnt4_q, 4'b0100);
    @(negedge clk) lock4 = 1'b1;
    @(posedge clk);
    @(negedge clk) req4 = 4'b0101;
    #1;
    check("lock_comb_grant", gnt4, 4'b0001);
    @(posedge clk) #1;
    check("lock_hold_q", gnt4_q, 4'b0100);
    check("lock_hold_index_q", idx4_q, 2'd2);
    @(negedge clk) req4 = 4'b0001;
    @(posedge clk) #1;
    check("lock_release_q", gnt4_q, 4'b0001);
    check("lock_release_index_q", idx4_q, 2'd0);

    // Lock held but all requests dropped: grant goes empty.
    @(negedge clk) req4 = 4'b0000;
    @(posedge clk) #1;
    check("lock_empty_q", gnt4_q, 4'b0000);
    check("lock_empty_valid_q", vld4_q, 1'b0);

    // No lock: higher-priority request takes over one cycle later.
    @(negedge clk) begin lock4 = 1'b0; req4 = 4'b0100; end
    @(posedge clk) #1;
    check("nolock_first_q", gnt4_q, 4'b0100);
    @(negedge clk) req4 = 4'b0101;
    @(posedge clk) #1;
    check("nolock_switch_q", gnt4_q, 4'b0001);

    // Reset asserted mid-lock clears immediately; lock is lost afterwards.
    @(negedge clk) req4 = 4'b0100;
    @(posedge clk);
    @(negedge clk) begin lock4 = 1'b1; req4 = 4'b0101; end
    @(posedge clk) #1;
    check("midlock_hold_q", gnt4_q, 4'b0100);
    #2 rst_x = 1'b0;
    #1;
    check("midlock_rst_q", gnt4_q, 4'b0000);
    check("midlock_rst_valid_q", vld4_q, 1'b0);
    @(posedge clk);
    @(negedge clk) rst_x = 1'b1;
    @(posedge clk) #1;
    check("midlock_after_q", gnt4_q, 4'b0001);
    check("midlock_after_index_q", idx4_q, 2'd0);
    @(negedge clk) lock4 = 1'b0;

    // Randomized width 8 (with lock) and width 1 against the reference model.
    for (int v = 0; v < 1000; v++) begin
      logic [7:0] r;
      logic       lk;
      int         own;
      int         win;
      @(negedge clk);
      r  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0 && ref_own8 >= 0) r[ref_own8] = 1'b1;
      lk = ($urandom_range(0, 3) != 0);
      req8 = r; lock8 = lk; req1 = 1'($urandom_range(0, 1));
      #1;
      win = lowest(32'(r), 8);
      check("rnd_onehot0", 32'($countones(gnt8) <= 1), 32'd1);
      check("rnd_subset", 32'(gnt8 & ~r), 32'd0);
      check("rnd_grant", gnt8, onehot(win));
      check("rnd_index", idx8, (win < 0) ? 0 : win);
      check("rnd_valid", vld8, r != 8'd0);
      check("w1_grant", gnt1, req1);
      check("w1_index", idx1, 0);
      own = ref_own8;
      if (!(lk && own >= 0 && r[own])) ref_own8 = win;
      ref_own1 = req1[0] ? 0 : -1;
      @(posedge clk) #1;
      check("rnd_grant_q", gnt8_q, onehot(ref_own8));
      check("rnd_index_q", idx8_q, (ref_own8 < 0) ? 0 : ref_own8);
      check("rnd_valid_q", vld8_q, ref_own8 >= 0);
      check("w1_grant_q", gnt1_q, onehot(ref_own1));
      check("w1_index_q", idx1_q, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
